// File: rtl/mem_data_memory_wb_reg.sv
// rtl/mem_data_memory_wb_reg.sv - MEM stage data memory with MEM/WB pipeline register
module mem_data_memory_wb_reg #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  load_mode,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_back,
    input  logic        mem_to_reg,
    output logic [31:0] mem_read_data,
    output logic [31:0] read_data,
    output logic [31:0] address_out,
    output logic        write_back_out,
    output logic        mem_to_reg_out
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] MODE_WORD  = 2'b00;
    localparam logic [1:0] MODE_HALF  = 2'b01;
    localparam logic [1:0] MODE_BYTES = 2'b10;

    logic [31:0] mem [DEPTH];

    // Upper address bits are dropped, so accesses wrap around the array.
    logic [DEPTH_LOG2-1:0] index;
    logic [31:0]           word;
    logic [15:0]           half;
    logic [7:0]            lane;

    assign index = address[DEPTH_LOG2+1:2];
    assign word  = mem[index];

    // Pick the addressed halfword and byte lane (little-endian).
    always_comb begin
        half = address[1] ? word[31:16] : word[15:0];
        case (address[1:0])
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            default: lane = word[31:24];
        endcase
    end

    // Format the load result; disabled loads read as zero.
    always_comb begin
        mem_read_data = 32'd0;
        if (mem_read) begin
            case (load_mode)
                MODE_WORD:  mem_read_data = word;
                MODE_HALF:  mem_read_data = {{16{half[15]}}, half};
                MODE_BYTES: mem_read_data = {{24{lane[7]}}, lane};
                default:    mem_read_data = {24'd0, lane};
            endcase
        end
    end

    // Memory array: cleared by reset, word stores on the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (mem_write) begin
            mem[index] <= write_data;
        end
    end

    // MEM/WB register: load data sees pre-store contents of this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data      <= 32'd0;
            address_out    <= 32'd0;
            write_back_out <= 1'b0;
            mem_to_reg_out <= 1'b0;
        end else begin
            read_data      <= mem_read_data;
            address_out    <= address;
            write_back_out <= write_back;
            mem_to_reg_out <= mem_to_reg;
        end
    end

endmodule

// File: tb/tb_mem_data_memory_wb_reg.sv
// tb/tb_mem_data_memory_wb_reg.sv - scoreboard bench for mem_data_memory_wb_reg
module tb_mem_data_memory_wb_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  load_mode;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_back;
    logic        mem_to_reg;
    logic [31:0] mem_read_data;
    logic [31:0] read_data;
    logic [31:0] address_out;
    logic        write_back_out;
    logic        mem_to_reg_out;

    mem_data_memory_wb_reg #(.DEPTH_LOG2(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .load_mode      (load_mode),
        .address        (address),
        .write_data     (write_data),
        .write_back     (write_back),
        .mem_to_reg     (mem_to_reg),
        .mem_read_data  (mem_read_data),
        .read_data      (read_data),
        .address_out    (address_out),
        .write_back_out (write_back_out),
        .mem_to_reg_out (mem_to_reg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] addr;
        logic        wb;
        logic        m2r;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [256];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference load: byte-addressed view of a word array, plain arithmetic.
    function automatic logic [31:0] model_load(input logic rd, input logic [1:0] mode,
                                               input logic [31:0] addr);
        logic [31:0] w;
        logic [31:0] v;
        if (!rd) return 32'd0;
        w = ref_mem[(addr / 4) % 256];
        case (mode)
            2'b00: v = w;
            2'b01: begin
                v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
                if (v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            2'b10: begin
                v = (w >> (8 * (addr % 4))) & 32'hFF;
                if (v >= 32'h80) v = v | 32'hFFFFFF00;
            end
            default: v = (w >> (8 * (addr % 4))) & 32'hFF;
        endcase
        return v;
    endfunction

    task automatic step(input logic rd, input logic wr, input logic [1:0] mode,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic wb, input logic m2r);
        exp_t e;
        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        load_mode  = mode;
        address    = addr;
        write_data = wdata;
        write_back = wb;
        mem_to_reg = m2r;
        #1;
        e.rd   = model_load(rd, mode, addr);
        e.addr = addr;
        e.wb   = wb;
        e.m2r  = m2r;
        check("mem_read_data", mem_read_data, e.rd);
        sb.push_back(e);
        if (wr) ref_mem[(addr / 4) % 256] = wdata;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " read_data"}, read_data, 32'd0);
        check({tag, " address_out"}, address_out, 32'd0);
        check({tag, " write_back_out"}, {31'd0, write_back_out}, 32'd0);
        check({tag, " mem_to_reg_out"}, {31'd0, mem_to_reg_out}, 32'd0);
    endtask

    // Monitor: each clock edge retires one issued operation from the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("read_data", read_data, e.rd);
                check("address_out", address_out, e.addr);
                check("write_back_out", {31'd0, write_back_out}, {31'd0, e.wb});
                check("mem_to_reg_out", {31'd0, mem_to_reg_out}, {31'd0, e.m2r});
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        rst        = 1'b1;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        load_mode  = 2'b00;
        address    = 32'h10;
        write_data = 32'd0;
        write_back = 1'b0;
        mem_to_reg = 1'b0;
        #3;
        check_outputs_zero("reset");
        check("reset mem_read_data", mem_read_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load
        step(0, 1, 2'b00, 32'h20, 32'hDEADBEEF, 0, 0);
        step(1, 0, 2'b00, 32'h20, 32'h0, 0, 0);

        // Sub-word loads
        step(0, 1, 2'b00, 32'h00, 32'h80F17F02, 0, 0);
        step(1, 0, 2'b10, 32'h03, 32'h0, 0, 0);
        step(1, 0, 2'b11, 32'h03, 32'h0, 0, 0);
        step(1, 0, 2'b10, 32'h01, 32'h0, 0, 0);
        step(1, 0, 2'b01, 32'h02, 32'h0, 0, 0);
        step(1, 0, 2'b01, 32'h00, 32'h0, 0, 0);
        step(1, 0, 2'b01, 32'h03, 32'h0, 0, 1);

        // Same-cycle read and write
        step(0, 1, 2'b00, 32'h40, 32'h11111111, 0, 0);
        step(1, 1, 2'b00, 32'h40, 32'h22222222, 0, 0);
        step(1, 0, 2'b00, 32'h40, 32'h0, 0, 0);

        // Wrap and one-cycle control pulse
        step(0, 1, 2'b00, 32'h400, 32'hA5A5A5A5, 1, 1);
        step(1, 0, 2'b00, 32'h000, 32'h0, 0, 0);
        step(1, 0, 2'b00, 32'hFFFFFC00, 32'h0, 0, 0);

        // Read disabled
        step(0, 0, 2'b00, 32'h20, 32'h0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom();
            if ($urandom_range(0, 1) == 0) a = a & 32'h3FF;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)), a, $urandom(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-cycle with a store pending
        step(1, 0, 2'b00, 32'h20, 32'h0, 1, 1);
        drain();
        @(negedge clk);
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        load_mode  = 2'b00;
        address    = 32'h10;
        write_data = 32'h12345678;
        write_back = 1'b1;
        mem_to_reg = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        check_outputs_zero("async reset");
        check("async reset mem_read_data", mem_read_data, 32'd0);
        @(posedge clk);
        #1;
        check_outputs_zero("held reset");
        check("held reset store lost", mem_read_data, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        mem_write = 1'b0;
        step(1, 0, 2'b00, 32'h10, 32'h0, 0, 0);
        step(1, 0, 2'b00, 32'h20, 32'h0, 0, 0);
        step(0, 1, 2'b00, 32'h10, 32'hCAFEF00D, 0, 1);
        step(1, 0, 2'b11, 32'h11, 32'h0, 1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
